// File: rtl/led_fade_if.sv
// Pattern-in / PWM-out bundle between the animation core and the LED fade stage.
interface led_fade_if #(
    parameter int unsigned N_LEDS = 8
);
    logic              fade_en;
    logic [N_LEDS-1:0] led_in;
    logic [N_LEDS-1:0] pwm_out;

    modport master (output fade_en, output led_in, input pwm_out);
    modport slave  (input fade_en, input led_in, output pwm_out);
endinterface

// File: rtl/led_fade_pwm.sv
// Per-LED PWM driver: full brightness while the pattern bit is high, then a
// linear fade-out paced by a shared prescaler tick.
module led_fade_pwm #(
    parameter int unsigned N_LEDS     = 8,
    parameter int unsigned BR_W       = 4,
    parameter int unsigned DECAY_DIV  = 1024,
    parameter int unsigned DECAY_STEP = 1
) (
    input logic       clk,
    input logic       rst,
    led_fade_if.slave bus
);

    localparam logic [BR_W-1:0]  MAX      = '1;
    localparam logic [BR_W-1:0]  PWM_LAST = MAX - BR_W'(1);
    localparam int unsigned      DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [BR_W-1:0]  STEP     = BR_W'(DECAY_STEP);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BR_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BR_W-1:0]   bright_q [N_LEDS];
    logic [BR_W-1:0]   bright_d [N_LEDS];
    logic [N_LEDS-1:0] pwm_out_q, pwm_out_d;
    logic              decay_tick;

    // PWM counter stops at MAX-1 so that bright==MAX yields a 100% duty cycle.
    always_comb begin
        decay_tick = (div_cnt_q == DIV_LAST);
        div_cnt_d  = decay_tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + BR_W'(1);
    end

    always_comb begin
        pwm_out_d = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            bright_d[i] = bright_q[i];
            if (!bus.fade_en) begin
                bright_d[i] = bus.led_in[i] ? MAX : '0;
            end else if (bus.led_in[i]) begin
                bright_d[i] = MAX;
            end else if (decay_tick) begin
                // Saturating decrement: a step larger than the remainder lands on 0.
                bright_d[i] = (bright_q[i] > STEP) ? bright_q[i] - STEP : '0;
            end
            pwm_out_d[i] = (bright_q[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            pwm_out_q <= '0;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                bright_q[i] <= '0;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                bright_q[i] <= bright_d[i];
            end
        end
    end

    assign bus.pwm_out = pwm_out_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances (DECAY_STEP 1 and 4, DECAY_DIV 4) checked
// every cycle against a behavioural model via a scoreboard queue, plus directed checks.
module tb_led_fade_pwm;

    localparam int DIV  = 4;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       fade_en;
    logic [7:0] led_in;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_br [2][8];
    int          m_pwm = 0;
    int          m_div = 0;
    int          m_step [2] = '{1, 4};
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    led_fade_if #(.N_LEDS(8)) bus1 ();
    led_fade_if #(.N_LEDS(8)) bus4 ();

    assign bus1.fade_en = fade_en;
    assign bus1.led_in  = led_in;
    assign bus4.fade_en = fade_en;
    assign bus4.led_in  = led_in;

    led_fade_pwm #(.N_LEDS(8), .BR_W(4), .DECAY_DIV(DIV), .DECAY_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    led_fade_pwm #(.N_LEDS(8), .BR_W(4), .DECAY_DIV(DIV), .DECAY_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge; pushes the pwm_out expected after it.
    task automatic model_step();
        logic [7:0] e [2];
        bit         tk;
        tk = (m_div == DIV - 1);
        for (int c = 0; c < 2; c++) begin
            e[c] = '0;
            for (int i = 0; i < 8; i++) begin
                e[c][i] = (m_br[c][i] > m_pwm);
                if (rst)                 m_br[c][i] = 0;
                else if (led_in[i])      m_br[c][i] = MAXV;
                else if (!fade_en)       m_br[c][i] = 0;
                else if (tk) begin
                    m_br[c][i] = m_br[c][i] - m_step[c];
                    if (m_br[c][i] < 0) m_br[c][i] = 0;
                end
            end
            if (rst) e[c] = '0;
        end
        if (rst) begin
            m_pwm = 0;
            m_div = 0;
        end else begin
            m_pwm = (m_pwm + 1) % MAXV;
            m_div = (m_div + 1) % DIV;
        end
        exp_q.push_back({e[1], e[0]});
    endtask

    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("pwm_s1", int'(bus1.pwm_out), int'(e[7:0]));
            chk("pwm_s4", int'(bus4.pwm_out), int'(e[15:8]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         prev;
        int         guard;
        logic [7:0] d1, d2;

        // Reset held with all pattern bits high, then release.
        rst = 1'b1; fade_en = 1'b1; led_in = 8'hFF;
        repeat (5) begin
            tick();
            chk("rst_out", int'(bus1.pwm_out), 0);
        end
        rst = 1'b0;
        tick(); chk("rel_e1", int'(bus1.pwm_out), 0);
        tick(); chk("rel_e2", int'(bus1.pwm_out), 8'hFF);

        // Fresh start, single channel held on.
        rst = 1'b1; led_in = 8'h00;
        repeat (2) tick();
        rst = 1'b0; led_in = 8'h01;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k >= 2) chk("hold_on", int'(bus1.pwm_out[0]), 1);
            chk("hold_off", int'(bus1.pwm_out[7:1]), 0);
        end

        // Fade-out: per-window high count must not rise and must reach zero.
        led_in = 8'h00;
        guard = 0;
        while (m_pwm != 0 && guard < 20) begin tick(); guard++; end
        chk("win_align", int'(m_pwm), 0);
        prev = MAXV + 1;
        cnt  = 0;
        for (int w = 0; w < 6; w++) begin
            cnt = 0;
            for (int k = 0; k < MAXV; k++) begin
                tick();
                cnt += int'(bus1.pwm_out[0]);
            end
            chk("win_mono", (cnt <= prev) ? 1 : 0, 1);
            prev = cnt;
        end
        chk("win_end", cnt, 0);

        // Retrigger on the same edge as a decay tick.
        led_in = 8'h01; tick();
        led_in = 8'h00;
        guard = 0;
        while (!(m_br[0][0] == 5 && m_div == DIV - 1) && guard < 200) begin
            tick(); guard++;
        end
        chk("retrig_wait", (guard < 200) ? 1 : 0, 1);
        led_in = 8'h01;
        tick();
        tick(); chk("retrig", int'(bus1.pwm_out[0]), 1);
        repeat (15) begin
            tick();
            chk("retrig_full", int'(bus1.pwm_out[0]), 1);
        end

        // Bypass: output follows the pattern two edges late, no tail.
        fade_en = 1'b0;
        d1 = led_in; d2 = led_in;
        for (int k = 0; k < 80; k++) begin
            led_in = ((k / 20) % 2 == 0) ? 8'hAA : 8'h55;
            d2 = d1; d1 = led_in;
            tick();
            if (k >= 1) begin
                chk("byp_s1", int'(bus1.pwm_out), int'(d2));
                chk("byp_s4", int'(bus4.pwm_out), int'(d2));
            end
        end

        // Fade with both step sizes, then reset mid-fade.
        fade_en = 1'b1; led_in = 8'hFF;
        repeat (2) tick();
        led_in = 8'h00;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid1", int'(bus1.pwm_out), 0);
        chk("rst_mid4", int'(bus4.pwm_out), 0);
        rst = 1'b0;
        repeat (20) tick();
        led_in = 8'hF0; tick();
        led_in = 8'h00;
        repeat (80) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
